rps_result_display: RTL

//  Output stage after the rock/paper/scissors classifier. Accepts one class result per valid/ready

---
 rtl/rps_result_display.sv | 129 ++++++++++++
 1 files changed

// File: rtl/rps_result_display.sv
// ----------------------------------------------------------------------------
// rps_result_display
//   Output stage after the rock/paper/scissors classifier. It accepts one class
//   result per valid/ready handshake and latches it. It then drives the
//   active-low RGB pins with a PWM-dimmed colour for that class. Each accepted
//   result stays on screen for at least HOLD_CYCLES cycles before the next one
//   is taken.
//
// Parameters
//   HOLD_CYCLES  minimum cycles a result is held before the next is accepted (>=1)
//   PWM_BITS     width of the free-running PWM counter
//   DUTY         pins are lit while pwm_cnt < DUTY (0..2**PWM_BITS)
//
// Ports
//   fpga_clk     in   1  system clock
//   fpga_rst_n   in   1  synchronous reset, active-low
//   class_valid  in   1  classifier result valid
//   class_ready  out  1  display can accept a result (registered)
//   class_id     in   2  0=rock 1=paper 2=scissors 3=none
//   breadboard   out  3  RGB pins, active-low (1 = off), registered
//   LED          out  6  [1:0] latched class, [2] hold active, [5:3] accept count
// ----------------------------------------------------------------------------
module rps_result_display #(
  parameter int HOLD_CYCLES = 25_000_000,
  parameter int PWM_BITS    = 8,
  parameter int DUTY        = 64
) (
  input  logic       fpga_clk,
  input  logic       fpga_rst_n,
  input  logic       class_valid,
  output logic       class_ready,
  input  logic [1:0] class_id,
  output logic [2:0] breadboard,
  output logic [5:0] LED
);

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  // One extra bit so DUTY == 2**PWM_BITS (always lit) is representable.
  localparam logic [PWM_BITS:0] DUTY_W = (PWM_BITS + 1)'(DUTY);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    SHOW = 2'd2
  } state_t;

  state_t              state_r;
  logic [1:0]          class_r;
  logic [HOLD_W-1:0]   hold_cnt_r;
  logic [PWM_BITS-1:0] pwm_cnt_r;
  logic [2:0]          acc_cnt_r;
  logic                xfer_s;
  logic                pwm_lit_s;

  // Active-low colour for each class; class 3 ("none") shows nothing.
  function automatic logic [2:0] class_pattern(input logic [1:0] c);
    logic [2:0] p;
    case (c)
      2'd0:    p = 3'b011;
      2'd1:    p = 3'b101;
      2'd2:    p = 3'b110;
      default: p = 3'b111;
    endcase
    return p;
  endfunction

  // Handshake and PWM phase decode.
  always_comb begin
    xfer_s    = class_valid & class_ready;
    pwm_lit_s = ({1'b0, pwm_cnt_r} < DUTY_W);
  end

  // Display FSM, PWM counter and all registered outputs.
  always_ff @(posedge fpga_clk) begin
    if (!fpga_rst_n) begin
      state_r     <= IDLE;
      class_r     <= 2'd3;
      hold_cnt_r  <= '0;
      pwm_cnt_r   <= '0;
      acc_cnt_r   <= 3'd0;
      class_ready <= 1'b1;
      breadboard  <= 3'b111;
      LED         <= 6'b000011;
    end else begin
      pwm_cnt_r <= pwm_cnt_r + 1'b1;
      // Pattern uses the registered state/class, giving one cycle of latency
      // from the transfer edge and a glitch-free pin drive.
      if (pwm_lit_s && (state_r != IDLE)) begin
        breadboard <= class_pattern(class_r);
      end else begin
        breadboard <= 3'b111;
      end

      case (state_r)
        IDLE, SHOW: begin
          if (xfer_s) begin
            state_r     <= HOLD;
            class_r     <= class_id;
            hold_cnt_r  <= '0;
            acc_cnt_r   <= acc_cnt_r + 3'd1;
            class_ready <= 1'b0;
            LED         <= {acc_cnt_r + 3'd1, 1'b1, class_id};
          end else begin
            class_ready <= 1'b1;
            LED         <= {acc_cnt_r, 1'b0, class_r};
          end
        end
        HOLD: begin
          if (hold_cnt_r == HOLD_LAST) begin
            state_r     <= SHOW;
            class_ready <= 1'b1;
            LED         <= {acc_cnt_r, 1'b0, class_r};
          end else begin
            hold_cnt_r  <= hold_cnt_r + 1'b1;
            class_ready <= 1'b0;
            LED         <= {acc_cnt_r, 1'b1, class_r};
          end
        end
        default: begin
          state_r     <= IDLE;
          class_ready <= 1'b1;
          LED         <= {acc_cnt_r, 1'b0, class_r};
        end
      endcase
    end
  end

endmodule
